// File: rtl/cpu_decode_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_decode_if
//  Description : Decode-stage bus bundle: fetched instruction, pipeline
//                control, register-bank write port and registered ID/EX
//                outputs toward the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_decode_if;
    // decode_if side
    logic [31:0] instr;
    logic [31:0] next_PC;
    logic        stall;
    logic        flush;
    // writeback port into the register bank
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    // execute_if side (ID/EX register)
    logic [31:0] ex_next_PC;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic [4:0]  reg_a;
    logic [4:0]  reg_b;
    logic [4:0]  reg_d;
    logic [31:0] imm;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic        branch;
    logic        jump;
    logic        illegal;

    modport master (
        output instr, next_PC, stall, flush, wb_en, wb_addr, wb_data,
        input  ex_next_PC, ra_data, rb_data, reg_a, reg_b, reg_d, imm,
               alu_op, alu_src_imm, reg_write, mem_read, mem_write,
               mem_byte, branch, jump, illegal
    );

    modport slave (
        input  instr, next_PC, stall, flush, wb_en, wb_addr, wb_data,
        output ex_next_PC, ra_data, rb_data, reg_a, reg_b, reg_d, imm,
               alu_op, alu_src_imm, reg_write, mem_read, mem_write,
               mem_byte, branch, jump, illegal
    );
endinterface
`default_nettype wire

// File: rtl/cpu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_decode
//  Description : Instruction decode stage with 32x32 register bank and the
//                ID/EX pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_decode (
    input  wire logic   clock,
    input  wire logic   reset,
    cpu_decode_if.slave bus
);
    localparam logic [2:0] c_alu_add  = 3'b000;
    localparam logic [2:0] c_alu_sub  = 3'b001;
    localparam logic [2:0] c_alu_mul  = 3'b010;
    localparam logic [2:0] c_alu_passb = 3'b011;

    logic [31:0] r_bank [32];

    logic [6:0]  w_opcode;
    logic [4:0]  w_dst;
    logic [4:0]  w_src1;
    logic [4:0]  w_src2;
    logic [4:0]  w_reg_b;
    logic [31:0] w_ra_data;
    logic [31:0] w_rb_data;
    logic [31:0] w_imm;
    logic [2:0]  w_alu_op;
    logic        w_alu_src_imm;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_mem_byte;
    logic        w_branch;
    logic        w_jump;
    logic        w_illegal;

    assign w_opcode = bus.instr[31:25];
    assign w_dst    = bus.instr[24:20];
    assign w_src1   = bus.instr[19:15];
    assign w_src2   = bus.instr[14:10];

    // Control decode; unknown opcodes become a bubble flagged illegal.
    always_comb begin
        w_imm         = 32'd0;
        w_alu_op      = c_alu_add;
        w_alu_src_imm = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_mem_byte    = 1'b0;
        w_branch      = 1'b0;
        w_jump        = 1'b0;
        w_illegal     = 1'b0;
        w_reg_b       = w_src2;
        case (w_opcode)
            7'h00: begin w_alu_op = c_alu_add; w_reg_write = 1'b1; end
            7'h01: begin w_alu_op = c_alu_sub; w_reg_write = 1'b1; end
            7'h02: begin w_alu_op = c_alu_mul; w_reg_write = 1'b1; end
            7'h10, 7'h11: begin
                w_imm         = {{17{bus.instr[14]}}, bus.instr[14:0]};
                w_alu_src_imm = 1'b1;
                w_mem_read    = 1'b1;
                w_reg_write   = 1'b1;
                w_mem_byte    = ~w_opcode[0];
            end
            7'h12, 7'h13: begin
                // Store data comes from the dst field, read on port B.
                w_imm         = {{17{bus.instr[14]}}, bus.instr[14:0]};
                w_alu_src_imm = 1'b1;
                w_mem_write   = 1'b1;
                w_mem_byte    = ~w_opcode[0];
                w_reg_b       = w_dst;
            end
            7'h14: begin
                w_imm         = {{12{bus.instr[19]}}, bus.instr[19:0]};
                w_alu_op      = c_alu_passb;
                w_alu_src_imm = 1'b1;
                w_reg_write   = 1'b1;
            end
            7'h30: begin
                w_imm    = {{17{bus.instr[24]}}, bus.instr[24:20], bus.instr[9:0]};
                w_alu_op = c_alu_sub;
                w_branch = 1'b1;
            end
            7'h31: begin
                w_imm         = {{17{bus.instr[24]}}, bus.instr[24:20], bus.instr[9:0]};
                w_alu_src_imm = 1'b1;
                w_jump        = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Register read with r0 hardwired to zero and writeback bypass.
    always_comb begin
        w_ra_data = r_bank[w_src1];
        w_rb_data = r_bank[w_reg_b];
        if (bus.wb_en && bus.wb_addr == w_src1)  w_ra_data = bus.wb_data;
        if (bus.wb_en && bus.wb_addr == w_reg_b) w_rb_data = bus.wb_data;
        if (w_src1 == 5'd0)  w_ra_data = 32'd0;
        if (w_reg_b == 5'd0) w_rb_data = 32'd0;
    end

    // Register bank write port; reset clears the bank and drops any write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_bank[i] <= 32'd0;
        end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
            r_bank[bus.wb_addr] <= bus.wb_data;
        end
    end

    // ID/EX register: reset/flush load a zero bubble, stall holds.
    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            bus.ex_next_PC  <= 32'd0;
            bus.ra_data     <= 32'd0;
            bus.rb_data     <= 32'd0;
            bus.reg_a       <= 5'd0;
            bus.reg_b       <= 5'd0;
            bus.reg_d       <= 5'd0;
            bus.imm         <= 32'd0;
            bus.alu_op      <= 3'd0;
            bus.alu_src_imm <= 1'b0;
            bus.reg_write   <= 1'b0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_byte    <= 1'b0;
            bus.branch      <= 1'b0;
            bus.jump        <= 1'b0;
            bus.illegal     <= 1'b0;
        end else if (!bus.stall) begin
            bus.ex_next_PC  <= bus.next_PC;
            bus.ra_data     <= w_ra_data;
            bus.rb_data     <= w_rb_data;
            bus.reg_a       <= w_src1;
            bus.reg_b       <= w_reg_b;
            bus.reg_d       <= w_dst;
            bus.imm         <= w_imm;
            bus.alu_op      <= w_alu_op;
            bus.alu_src_imm <= w_alu_src_imm;
            bus.reg_write   <= w_reg_write;
            bus.mem_read    <= w_mem_read;
            bus.mem_write   <= w_mem_write;
            bus.mem_byte    <= w_mem_byte;
            bus.branch      <= w_branch;
            bus.jump        <= w_jump;
            bus.illegal     <= w_illegal;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cpu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_decode
//  Description : Directed self-checking bench for cpu_decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_decode;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    cpu_decode_if bus ();

    cpu_decode dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {alu_op, alu_src_imm, reg_write, mem_read, mem_write, mem_byte, branch, jump, illegal}
    function automatic logic [31:0] ctrl();
        return {21'd0, bus.alu_op, bus.alu_src_imm, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.mem_byte, bus.branch, bus.jump, bus.illegal};
    endfunction

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.wb_en = en; bus.wb_addr = a; bus.wb_data = d;
    endtask

    initial begin
        reset = 1'b1;
        bus.instr = {7'h00, 5'd1, 5'd1, 5'd2, 10'd0};
        bus.next_PC = 32'h1234;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        wb(1'b1, 5'd5, 32'h55);           // must be discarded by reset
        tick();
        chk("rst_ctrl", ctrl(), 32'd0);
        chk("rst_pc", bus.ex_next_PC, 32'd0);
        chk("rst_ra", bus.ra_data, 32'd0);
        chk("rst_rb", bus.rb_data, 32'd0);
        chk("rst_idx", {17'd0, bus.reg_a, bus.reg_b, bus.reg_d}, 32'd0);
        chk("rst_imm", bus.imm, 32'd0);
        reset = 1'b0;

        // preload r1=4, r2=5, r3=9
        bus.instr = 32'd0;
        wb(1'b1, 5'd1, 32'd4); tick();
        wb(1'b1, 5'd2, 32'd5); tick();
        wb(1'b1, 5'd3, 32'd9); tick();
        wb(1'b0, 5'd0, 32'd0);

        // SUB r0, r2, r1
        bus.instr = {7'h01, 5'h0, 5'h2, 5'h1, 10'h0};
        bus.next_PC = 32'd1;
        tick();
        chk("sub_ra", bus.ra_data, 32'd5);
        chk("sub_rb", bus.rb_data, 32'd4);
        chk("sub_idx", {22'd0, bus.reg_a, bus.reg_b}, {22'd0, 5'd2, 5'd1});
        chk("sub_ctrl", ctrl(), {21'd0, 3'b001, 8'b0100_0000});
        chk("sub_pc", bus.ex_next_PC, 32'd1);
        chk("sub_imm", bus.imm, 32'd0);

        // STW r3 -> [r1 + 0x7FFF]
        bus.instr = {7'h13, 5'd3, 5'd1, 15'h7FFF};
        bus.next_PC = 32'd2;
        tick();
        chk("stw_imm", bus.imm, 32'hFFFF_FFFF);
        chk("stw_rb", bus.rb_data, 32'd9);
        chk("stw_regb", {27'd0, bus.reg_b}, 32'd3);
        chk("stw_ra", bus.ra_data, 32'd4);
        chk("stw_ctrl", ctrl(), {21'd0, 3'b000, 8'b1001_0000});

        // LDB r4 <- [r1 + 0x10]
        bus.instr = {7'h10, 5'd4, 5'd1, 15'h0010};
        tick();
        chk("ldb_ctrl", ctrl(), {21'd0, 3'b000, 8'b1110_1000});
        chk("ldb_imm", bus.imm, 32'h10);
        chk("ldb_regd", {27'd0, bus.reg_d}, 32'd4);

        // bypass: write r2=AB while ADD reads r2
        wb(1'b1, 5'd2, 32'hAB);
        bus.instr = {7'h00, 5'd5, 5'd2, 5'd0, 10'd0};
        tick();
        chk("byp_ra", bus.ra_data, 32'hAB);
        chk("byp_rb", bus.rb_data, 32'd0);

        // write to r0 ignored; r5 write during reset was discarded
        wb(1'b1, 5'd0, 32'h77);
        bus.instr = {7'h00, 5'd6, 5'd5, 5'd0, 10'd0};
        tick();
        chk("r5_ra", bus.ra_data, 32'd0);
        chk("r0_rb", bus.rb_data, 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        bus.instr = {7'h00, 5'd6, 5'd0, 5'd0, 10'd0};
        tick();
        chk("r0_after", bus.ra_data, 32'd0);

        // MOV r6 <- sext(0xFFFF0)
        bus.instr = {7'h14, 5'd6, 20'hFFFF0};
        bus.next_PC = 32'd7;
        tick();
        chk("mov_imm", bus.imm, 32'hFFFF_FFF0);
        chk("mov_ctrl", ctrl(), {21'd0, 3'b011, 8'b1100_0000});

        // stall with new instr and a bank write to r1
        bus.stall = 1'b1;
        wb(1'b1, 5'd1, 32'h11);
        bus.instr = {7'h13, 5'd3, 5'd1, 15'h0001};
        bus.next_PC = 32'd8;
        tick();
        chk("stl_ctrl", ctrl(), {21'd0, 3'b011, 8'b1100_0000});
        chk("stl_imm", bus.imm, 32'hFFFF_FFF0);
        chk("stl_pc", bus.ex_next_PC, 32'd7);
        bus.stall = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        bus.instr = {7'h01, 5'd0, 5'd1, 5'd2, 10'd0};
        tick();
        chk("stl_wr", bus.ra_data, 32'h11);
        chk("stl_rb", bus.rb_data, 32'hAB);

        // flush with a bank write to r7
        bus.flush = 1'b1;
        wb(1'b1, 5'd7, 32'h70);
        tick();
        chk("fl_ctrl", ctrl(), 32'd0);
        chk("fl_ra", bus.ra_data, 32'd0);
        chk("fl_pc", bus.ex_next_PC, 32'd0);
        bus.flush = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        bus.instr = {7'h00, 5'd1, 5'd7, 5'd0, 10'd0};
        tick();
        chk("fl_wr", bus.ra_data, 32'h70);

        // flush and stall together: flush wins
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        tick();
        chk("fs_ctrl", ctrl(), 32'd0);
        chk("fs_ra", bus.ra_data, 32'd0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // illegal opcode, then legal instr clears it
        bus.instr = {7'h7F, 5'd1, 5'd1, 5'd2, 10'd0};
        tick();
        chk("ill_ctrl", ctrl(), 32'd1);
        chk("ill_ra", bus.ra_data, 32'h11);
        chk("ill_regd", {27'd0, bus.reg_d}, 32'd1);
        bus.instr = {7'h00, 5'd1, 5'd1, 5'd2, 10'd0};
        tick();
        chk("ill_clr", ctrl(), {21'd0, 3'b000, 8'b0100_0000});

        // BEQ
        bus.instr = {7'h30, 5'h10, 5'd1, 5'd2, 10'h001};
        tick();
        chk("beq_imm", bus.imm, 32'hFFFF_C001);
        chk("beq_ctrl", ctrl(), {21'd0, 3'b001, 8'b0000_0100});

        // JUMP
        bus.instr = {7'h31, 5'h01, 10'd0, 10'h3FF};
        tick();
        chk("jmp_imm", bus.imm, 32'h0000_07FF);
        chk("jmp_ctrl", ctrl(), {21'd0, 3'b000, 8'b1000_0010});

        // reset clears the bank
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.instr = {7'h00, 5'd0, 5'd1, 5'd2, 10'd0};
        tick();
        chk("rst_bank_a", bus.ra_data, 32'd0);
        chk("rst_bank_b", bus.rb_data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
